dab_pattern_decoder: RTL and testbench
======================================

# dab_pattern_decoder

Measures the three-level bridge voltage patterns V1 and V2 produced by the DAB modulator and recovers the modulation parameters in clock counts: switching period, primary pulse width (tau1), secondary pulse width (tau2) and signed phase shift (phi). It sits on the feedback side of the converter controller, next to the modulator. It checks commanded against actual patterns and reports loss of switching activity.

## Interface
Parameters:
- CNT_W, 19: width of all count outputs and internal counters.
- TIMEOUT, 250000: maximum cycles between consecutive V1 reference edges before activity is declared lost. Must be < 2^(CNT_W-1).

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  measurement enable.
- v1_in  in  2 signed  primary voltage level: +1, 0 or -1 (2'b10 is treated as 0).
- v2_in  in  2 signed  secondary voltage level, same encoding.
- period_cnt  out  CNT_W unsigned  last measured period.
- tau1_cnt  out  CNT_W unsigned  last V1 positive-pulse width.
- tau2_cnt  out  CNT_W unsigned  last V2 positive-pulse width.
- phi_cnt  out  CNT_W signed  last phase shift, V2 relative to V1.
- meas_valid  out  1  one-cycle strobe when new results are published.
- locked  out  1  at least one valid measurement since the last arm.
- asym_err  out  1  registered with each publish; V1 positive and negative widths differ by more than 1.
- timeout_err  out  1  one-cycle strobe on activity loss.

## Operation
- Input stage: v1_q <= v1_in, v1_d <= v1_q; v2 is registered the same way.
- Reference edge: v1_fall = (v1_d == +1) && (v1_q != +1). v2_fall is defined the same way on V2. These are the end-of-positive-pulse instants, matching the modulator's pi and pi+phi transitions.
- FSM states:
  - IDLE: on en=1, go to ARM.
  - ARM: on v1_fall, go to MEAS and clear all window counters.
  - MEAS: on each v1_fall, publish results and restart the window.
  - en=0 in any state: go to IDLE on the next edge.
- Window: runs from a v1_fall cycle (inclusive) to the next v1_fall cycle (exclusive). The following counters run over the window:
  - per_ctr: cycles in the window.
  - pos1: cycles with v1_q == +1.
  - neg1: cycles with v1_q == -1.
  - pos2: cycles with v2_q == +1.
  - d: latched as the per_ctr value at the first v2_fall in the window. A v2_fall in the same cycle as v1_fall gives d = 0 for the new window. v2_seen flags that a v2_fall occurred.
- Publish, on v1_fall in MEAS:
  - period_cnt = per_ctr; tau1_cnt = pos1; tau2_cnt = pos2.
  - phi_cnt = d if d < (per_ctr >> 1), else d - per_ctr. The range is [-period/2, period/2).
  - If v2_seen = 0, phi_cnt = 0 and tau2_cnt = pos2 (normally 0).
  - asym_err = (|pos1 - neg1| > 1).
  - meas_valid = 1 for one cycle; locked = 1.
- Timeout: if per_ctr reaches TIMEOUT in MEAS, or the ARM dwell reaches TIMEOUT, then:
  - timeout_err pulses for one cycle;
  - locked = 0;
  - state goes to ARM;
  - published outputs are held.
- en deassert: locked is cleared and published outputs are held.
- Counters saturate at TIMEOUT and never wrap.

## Timing
- Reset: all outputs 0, including phi_cnt, meas_valid, locked, asym_err and timeout_err. State is IDLE and all internal registers are 0.
- Latency: a v1_in transition away from +1 is sampled at edge N. v1_fall is true in cycle N→N+1. The outputs and meas_valid register at edge N+1.
- Outputs are stable between strobes. meas_valid and timeout_err are never high in the same cycle; timeout has priority.
- Simultaneous v1_fall and timeout: the timeout is taken and no publish occurs.
- Reset asserted mid-window: immediate clear. The first publish occurs only after two v1_fall events following release and en.
- First v1_fall after arm: starts the window only, no publish.

## Test plan
- Nominal: period 200 cycles. V1 is 0 for 60, +1 for 40, 0 for 60, -1 for 40; V2 is the same pattern delayed 25 cycles. Required from the second V1 period on: period_cnt=200, tau1_cnt=40, tau2_cnt=40, phi_cnt=+25, asym_err=0, locked=1, one meas_valid per 200 cycles.
- Negative phase: as nominal, but V2 leads by 30 with tau2=50. Required: phi_cnt=-30 (0x7FFE2 at CNT_W=19), tau2_cnt=50.
- Asymmetry: V1 negative pulse widened to 45, period 205. Required: asym_err=1, tau1_cnt=40, period_cnt=205.
- Timeout: TIMEOUT=1000 with V1 stuck at 0 after lock. Required: timeout_err pulse exactly 1000 cycles after the last v1_fall, locked=0, outputs hold their last values. Resuming switching gives a new publish after two falls.
- Reset and enable: rst_n low mid-window clears all outputs asynchronously. en low for 10 cycles gives locked=0 with no meas_valid. Re-enable gives the first meas_valid at the second v1_fall.
- Coincident edges: V2 identical to V1 (phi 0). Required: phi_cnt=0 every period and no spurious strobes.

Source files
------------

// File: rtl/dab_pattern_decoder.sv
// dab_pattern_decoder: recovers switching period, pulse widths and signed phase shift
// from the three-level DAB bridge patterns V1/V2. It also flags loss of switching activity.
module dab_pattern_decoder #(
    parameter int CNT_W   = 19,
    parameter int TIMEOUT = 250000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [1:0]       v1_in,
    input  logic signed [1:0]       v2_in,
    output logic [CNT_W-1:0]        period_cnt,
    output logic [CNT_W-1:0]        tau1_cnt,
    output logic [CNT_W-1:0]        tau2_cnt,
    output logic signed [CNT_W-1:0] phi_cnt,
    output logic                    meas_valid,
    output logic                    locked,
    output logic                    asym_err,
    output logic                    timeout_err
);
    // 2'b10 matches neither level code, so it naturally counts as 0.
    localparam logic [1:0]       LVL_POS = 2'b01;
    localparam logic [1:0]       LVL_NEG = 2'b11;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    state_t state, state_nxt;

    logic [1:0]       v1_q, v1_d, v2_q, v2_d;
    logic [CNT_W-1:0] per_ctr, pos1, neg1, pos2, d;
    logic             v2_seen;
    logic             v1_pos, v1_neg, v2_pos, v1_fall, v2_fall;
    logic             tmo, restart, publish;
    logic [CNT_W-1:0] phi_val;
    logic             asym_val;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= TMO) ? TMO : c + ONE;
    endfunction

    assign v1_pos  = (v1_q == LVL_POS);
    assign v1_neg  = (v1_q == LVL_NEG);
    assign v2_pos  = (v2_q == LVL_POS);
    assign v1_fall = (v1_d == LVL_POS) && !v1_pos;
    assign v2_fall = (v2_d == LVL_POS) && !v2_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // per_ctr doubles as the ARM dwell counter, so one compare covers both timeouts.
    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        restart   = 1'b0;
        publish   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = ARM;
                ARM: begin
                    if (per_ctr >= TMO) begin
                        tmo = 1'b1;
                    end else if (v1_fall) begin
                        restart   = 1'b1;
                        state_nxt = MEAS;
                    end
                end
                MEAS: begin
                    if (per_ctr >= TMO) begin
                        tmo       = 1'b1;
                        state_nxt = ARM;
                    end else if (v1_fall) begin
                        restart = 1'b1;
                        publish = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Phase folded into [-period/2, period/2).
    always_comb begin
        phi_val = '0;
        if (v2_seen) phi_val = (d < (per_ctr >> 1)) ? d : d - per_ctr;
        asym_val = (pos1 > neg1 + ONE) || (neg1 > pos1 + ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= '0;
            v1_d        <= '0;
            v2_q        <= '0;
            v2_d        <= '0;
            per_ctr     <= '0;
            pos1        <= '0;
            neg1        <= '0;
            pos2        <= '0;
            d           <= '0;
            v2_seen     <= 1'b0;
            period_cnt  <= '0;
            tau1_cnt    <= '0;
            tau2_cnt    <= '0;
            phi_cnt     <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            asym_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            v1_q        <= v1_in;
            v1_d        <= v1_q;
            v2_q        <= v2_in;
            v2_d        <= v2_q;
            meas_valid  <= publish;
            timeout_err <= tmo;
            if (!en || state == IDLE) begin
                per_ctr <= '0;
                pos1    <= '0;
                neg1    <= '0;
                pos2    <= '0;
                d       <= '0;
                v2_seen <= 1'b0;
            end else if (tmo) begin
                per_ctr <= '0;
            end else if (restart) begin
                // The fall cycle is the first cycle of the new window.
                per_ctr <= ONE;
                pos1    <= v1_pos ? ONE : '0;
                neg1    <= v1_neg ? ONE : '0;
                pos2    <= v2_pos ? ONE : '0;
                d       <= '0;
                v2_seen <= v2_fall;
            end else begin
                per_ctr <= sat_inc(per_ctr);
                if (v1_pos) pos1 <= sat_inc(pos1);
                if (v1_neg) neg1 <= sat_inc(neg1);
                if (v2_pos) pos2 <= sat_inc(pos2);
                if (v2_fall && !v2_seen) begin
                    d       <= per_ctr;
                    v2_seen <= 1'b1;
                end
            end
            if (publish) begin
                period_cnt <= per_ctr;
                tau1_cnt   <= pos1;
                tau2_cnt   <= pos2;
                phi_cnt    <= $signed(phi_val);
                asym_err   <= asym_val;
                locked     <= 1'b1;
            end else if (tmo || !en) begin
                locked <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dab_pattern_decoder.sv
// Scoreboard bench for dab_pattern_decoder: expected results are queued as V1 falls are driven
// and compared when meas_valid strobes.
module tb_dab_pattern_decoder;
    localparam int CNT_W = 19;
    localparam int TMO   = 1000;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en = 1'b0;
    logic signed [1:0]       v1_in = 2'b00;
    logic signed [1:0]       v2_in = 2'b00;
    logic [CNT_W-1:0]        period_cnt, tau1_cnt, tau2_cnt;
    logic signed [CNT_W-1:0] phi_cnt;
    logic                    meas_valid, locked, asym_err, timeout_err;

    dab_pattern_decoder #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .v1_in(v1_in), .v2_in(v2_in),
        .period_cnt(period_cnt), .tau1_cnt(tau1_cnt), .tau2_cnt(tau2_cnt),
        .phi_cnt(phi_cnt), .meas_valid(meas_valid), .locked(locked),
        .asym_err(asym_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {int per; int tau1; int tau2; int phi; bit asym; bit skip; bit gap;} exp_t;
    typedef struct {int per; int p1; int p2; int dly; bit asym; bit z10;} seg_t;

    exp_t q[$];
    seg_t segs[4];
    int   n_chk = 0, n_err = 0;
    int   cyc = 0, last_mv = -1, tmo_cyc = -1, n_tmo = 0;
    int   falls = 0, last_seg = -1;
    bit   last_pushed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int md(input int x, input int p);
        return ((x % p) + p) % p;
    endfunction

    // V1: 0 for 60, +1 for p1, 0 for 60, -1 for the rest. V2 falls dly cycles after V1.
    task automatic run_period(input int s, input int t0, input int t1);
        seg_t       g;
        int         f1, a2;
        logic [1:0] z, l1, l2;
        exp_t       e;
        g  = segs[s];
        f1 = 60 + g.p1;
        a2 = md(f1 + g.dly - g.p2, g.per);
        z  = g.z10 ? 2'b10 : 2'b00;
        for (int t = t0; t < t1; t++) begin
            l1 = (t < 60) ? z : (t < f1) ? 2'b01 : (t < f1 + 60) ? z : 2'b11;
            if (md(t - a2, g.per) < g.p2)                  l2 = 2'b01;
            else if (md(t - a2 - g.per / 2, g.per) < g.p2) l2 = 2'b11;
            else                                           l2 = z;
            if (t == f1 && en) begin
                if (falls > 0) begin
                    e.per  = g.per;  e.tau1 = g.p1; e.tau2 = g.p2;
                    e.phi  = g.dly;  e.asym = g.asym;
                    e.skip = (last_seg != s);
                    e.gap  = last_pushed && !e.skip;
                    q.push_back(e);
                    last_pushed = 1'b1;
                end else begin
                    last_pushed = 1'b0;
                end
                falls++;
                last_seg = s;
            end
            v1_in = l1;
            v2_in = l2;
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_period"}, 32'(period_cnt), 0);
        chk({pfx, "_tau1"}, 32'(tau1_cnt), 0);
        chk({pfx, "_tau2"}, 32'(tau2_cnt), 0);
        chk({pfx, "_phi"}, 32'(phi_cnt), 0);
        chk({pfx, "_mv"}, 32'(meas_valid), 0);
        chk({pfx, "_locked"}, 32'(locked), 0);
        chk({pfx, "_asym"}, 32'(asym_err), 0);
        chk({pfx, "_tmo"}, 32'(timeout_err), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (meas_valid || timeout_err) chk("mv_te_excl", 32'(meas_valid && timeout_err), 0);
        if (timeout_err) begin
            n_tmo++;
            tmo_cyc = cyc;
        end
        if (meas_valid) begin
            if (q.size() == 0) begin
                chk("spurious_mv", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("locked_at_mv", 32'(locked), 1);
                if (!e.skip) begin
                    chk("period", 32'(period_cnt), e.per);
                    chk("tau1", 32'(tau1_cnt), e.tau1);
                    chk("tau2", 32'(tau2_cnt), e.tau2);
                    chk("phi", 32'(phi_cnt), e.phi);
                    chk("asym", 32'(asym_err), 32'(e.asym));
                    if (e.gap) chk("mv_gap", cyc - last_mv, e.per);
                end
            end
            last_mv = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        segs[0] = '{per: 200, p1: 40, p2: 40, dly: 25,  asym: 1'b0, z10: 1'b0}; // nominal
        segs[1] = '{per: 200, p1: 40, p2: 50, dly: -30, asym: 1'b0, z10: 1'b0}; // V2 leads
        segs[2] = '{per: 205, p1: 40, p2: 40, dly: 25,  asym: 1'b1, z10: 1'b1}; // wide negative pulse
        segs[3] = '{per: 200, p1: 40, p2: 40, dly: 0,   asym: 1'b0, z10: 1'b1}; // V2 == V1

        repeat (3) @(posedge clk); #1;
        chk_zero("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        en = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("locked_pre", 32'(locked), 0);

        repeat (4) run_period(0, 0, 200);
        repeat (3) run_period(1, 0, 200);
        repeat (3) run_period(2, 0, 205);
        repeat (3) run_period(3, 0, 200);
        repeat (2) run_period(0, 0, 200);

        // Activity loss: V1 held at 0.
        v1_in = 2'b00;
        v2_in = 2'b00;
        repeat (1100) @(posedge clk); #1;
        chk("tmo_count", n_tmo, 1);
        chk("tmo_delay", tmo_cyc - last_mv, TMO);
        chk("tmo_locked", 32'(locked), 0);
        chk("tmo_hold_period", 32'(period_cnt), 200);
        chk("tmo_hold_tau1", 32'(tau1_cnt), 40);
        chk("tmo_hold_phi", 32'(phi_cnt), 25);
        falls = 0;
        repeat (3) run_period(0, 0, 200);

        // Enable dropped for 10 cycles.
        en = 1'b0;
        falls = 0;
        run_period(0, 0, 10);
        chk("en_locked", 32'(locked), 0);
        chk("en_hold_period", 32'(period_cnt), 200);
        chk("en_hold_tau2", 32'(tau2_cnt), 40);
        en = 1'b1;
        run_period(0, 10, 200);
        repeat (2) run_period(0, 0, 200);

        // Asynchronous reset mid-window.
        run_period(0, 0, 30);
        #2 rst_n = 1'b0;
        #1 chk_zero("amid");
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        falls = 0;
        repeat (3) run_period(0, 0, 200);

        repeat (5) @(posedge clk); #1;
        chk("q_drained", q.size(), 0);
        chk("tmo_total", n_tmo, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
